// File: rtl/memory_mc_pkg.sv
// Shared types and sizing helpers for the multi-channel memory controller.
// Used by memory_mc, its interface and its arbiter.
package mem_mc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        INIT   = 2'd2
    } state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    // $clog2 returns 0 for depth 1; an address port always needs at least one bit
    function automatic int safe_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/memory_mc_if.sv
// Flattened per-channel request/response bundle for memory_mc.
// The master modport is the requester side and the slave modport is the memory side.
interface memory_mc_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 2
);
    import mem_mc_pkg::*;

    localparam int ADDR_WIDTH = safe_addr_w(DEPTH);
    localparam int NBYTES     = bytes_per_word(WIDTH);

    logic [NUM_CH-1:0]            valid;
    logic [NUM_CH-1:0]            wr_rd;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic [NUM_CH*WIDTH-1:0]      w_data;
    logic [NUM_CH*NBYTES-1:0]     wstrb;
    logic [NUM_CH-1:0]            ready;
    logic [NUM_CH-1:0]            err;
    logic [WIDTH-1:0]             r_data;

    modport master (
        output valid, wr_rd, addr, w_data, wstrb,
        input  ready, err, r_data
    );

    modport slave (
        input  valid, wr_rd, addr, w_data, wstrb,
        output ready, err, r_data
    );

endinterface

// File: rtl/memory_mc_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping. The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter  int NUM_CH = 2,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx,
    output logic [PTR_W-1:0]  next_ptr
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        next_ptr  = ptr;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (en && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = PTR_W'(idx);
                next_ptr    = PTR_W'((idx + 1) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/memory_mc.sv
// Multi-channel single-array memory with round-robin arbitration and byte strobes.
// Optional MEM_RST_CLEAR_EN: reset walks through the array clearing one word per cycle.
//
// state  | meaning
// IDLE   | waiting for any valid; grants, performs the access and raises ready
// ACCESS | ready/err high for this single cycle, then back to IDLE
// INIT   | post-reset clear of word init_idx (MEM_RST_CLEAR_EN only)
module memory_mc
    import mem_mc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 2
) (
    input  logic         clk,
    input  logic         rst,
    memory_mc_if.slave   bus
);

    localparam int AW    = safe_addr_w(DEPTH);
    localparam int NB    = bytes_per_word(WIDTH);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    next_ptr;
    logic [PTR_W-1:0]    gidx;
    logic [NUM_CH-1:0]   grant;
    logic [NUM_CH-1:0]   ready_q;
    logic [NUM_CH-1:0]   err_q;
    logic [WIDTH-1:0]    r_data_q;
    logic [WIDTH-1:0]    mem [DEPTH];

    logic [AW-1:0]       g_addr;
    logic [WIDTH-1:0]    g_data;
    logic [NB-1:0]       g_strb;
    logic                g_wr;
    logic                in_range;
    logic                acc_we;

`ifdef MEM_RST_CLEAR_EN
    logic [AW-1:0]       init_idx;
    logic                clr_we;
`endif

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (bus.valid),
        .ptr       (ptr),
        .en        (state == IDLE),
        .grant     (grant),
        .grant_idx (gidx),
        .next_ptr  (next_ptr)
    );

    // Only the granted channel's request fields are looked at
    always_comb begin
        g_addr   = bus.addr[int'(gidx)*AW +: AW];
        g_data   = bus.w_data[int'(gidx)*WIDTH +: WIDTH];
        g_strb   = bus.wstrb[int'(gidx)*NB +: NB];
        g_wr     = bus.wr_rd[gidx];
        in_range = int'(g_addr) < DEPTH;
        acc_we   = !rst && (state == IDLE) && (|grant) && g_wr && in_range;
    end

`ifdef MEM_RST_CLEAR_EN
    assign clr_we = !rst && (state == INIT);
`endif

    // Array has no reset of its own so it can map onto plain storage
    always_ff @(posedge clk) begin
`ifdef MEM_RST_CLEAR_EN
        if (clr_we) begin
            mem[init_idx] <= '0;
        end
`endif
        if (acc_we) begin
            for (int b = 0; b < NB; b++) begin
                if (g_strb[b]) begin
                    mem[g_addr][8*b +: 8] <= g_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q  <= '0;
            err_q    <= '0;
            r_data_q <= '0;
            ptr      <= '0;
`ifdef MEM_RST_CLEAR_EN
            state    <= INIT;
            init_idx <= '0;
`else
            state    <= IDLE;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        ready_q  <= grant;
                        err_q    <= in_range ? '0 : grant;
                        r_data_q <= (!g_wr && in_range) ? mem[g_addr] : '0;
                        ptr      <= next_ptr;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready_q <= '0;
                    err_q   <= '0;
                    state   <= IDLE;
                end
                INIT: begin
`ifdef MEM_RST_CLEAR_EN
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.err    = err_q;
    assign bus.r_data = r_data_q;

endmodule

// File: tb/tb_memory_mc.sv
// Scoreboard bench for memory_mc (DEPTH=12 so out-of-range addresses are reachable).
// Stimulus pushes expected responses per channel; a negedge monitor pops and compares.
module tb_memory_mc;

    localparam int W  = 16;
    localparam int D  = 12;
    localparam int NC = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_mc_if #(.WIDTH(W), .DEPTH(D), .NUM_CH(NC)) bus ();

    memory_mc #(.WIDTH(W), .DEPTH(D), .NUM_CH(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        err;
        logic [15:0] rd;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          grant_log[$];
    logic [15:0] exp_mem [D];
    bit          mon_en = 1'b0;
    logic [1:0]  prev_ready = 2'b00;

`ifdef MEM_RST_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ready != 2'b00) begin
                int   ch;
                exp_t e;
                logic [1:0] e_err;
                ch = bus.ready[0] ? 0 : 1;
                chk("ready_onehot", 32'($onehot(bus.ready)), 32'd1);
                chk("ready_pulse_width", 32'(prev_ready), 32'd0);
                grant_log.push_back(ch);
                if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready ch=%0d actual=ready required=no_pending t=%0t", ch, $time);
                end else begin
                    e = (ch == 0) ? q0.pop_front() : q1.pop_front();
                    e_err = 2'b00;
                    if (e.err) e_err[ch] = 1'b1;
                    chk($sformatf("err_ch%0d", ch), 32'(bus.err), 32'(e_err));
                    chk($sformatf("r_data_ch%0d", ch), 32'(bus.r_data), 32'(e.rd));
                end
            end else if (bus.err != 2'b00) begin
                chk("err_without_ready", 32'(bus.err), 32'd0);
            end
            prev_ready = bus.ready;
        end
    end

    task automatic do_req(input int ch, input bit wr, input int a, input logic [15:0] d,
                          input logic [1:0] s, input bit e_err, input logic [15:0] e_rd,
                          input int exp_lat);
        exp_t e;
        int   lat;
        e.err = e_err;
        e.rd  = e_rd;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
        bus.wr_rd[ch]            = wr;
        bus.addr[ch*AW +: AW]    = AW'(a);
        bus.w_data[ch*W +: W]    = d;
        bus.wstrb[ch*2 +: 2]     = s;
        bus.valid[ch]            = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.ready[ch] && lat < 60);
        if (!bus.ready[ch]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout ch=%0d actual=no_ready required=ready t=%0t", ch, $time);
        end else if (exp_lat > 0) begin
            chk($sformatf("latency_ch%0d", ch), 32'(lat), 32'(exp_lat));
        end
        @(posedge clk);
        #1;
        bus.valid[ch] = 1'b0;
    endtask

    task automatic wr0(input int a, input logic [15:0] d, input logic [1:0] s);
        if (a < D) begin
            if (s[0]) exp_mem[a][7:0]  = d[7:0];
            if (s[1]) exp_mem[a][15:8] = d[15:8];
        end
        do_req(0, 1'b1, a, d, s, a >= D, 16'h0000, 1);
    endtask

    task automatic rd0(input int a);
        logic [15:0] e_rd;
        e_rd = (a < D) ? exp_mem[a] : 16'h0000;
        do_req(0, 1'b0, a, 16'h0000, 2'b00, a >= D, e_rd, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (D + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int lat;
        bus.valid  = '0;
        bus.wr_rd  = '0;
        bus.addr   = '0;
        bus.w_data = '0;
        bus.wstrb  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bus.ready), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_r_data", 32'(bus.r_data), 32'd0);
        rst = 1'b0;
        repeat (D + 2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Address walk 0..15: 12..15 are out of range on this build
        for (int a = 0; a < 16; a++) begin
            d = 16'((a * 16'h1357) ^ 16'hC0DE);
            wr0(a, d, 2'b11);
        end
        for (int a = 0; a < 16; a++) rd0(a);

        // Byte strobes, including an all-zero strobe and an upper-byte-only write
        wr0(3, 16'hA5A5, 2'b11);
        wr0(3, 16'h1234, 2'b01);
        do_req(0, 1'b0, 3, 16'h0000, 2'b00, 1'b0, 16'hA534, 1);
        wr0(3, 16'hFFFF, 2'b00);
        do_req(0, 1'b0, 3, 16'h0000, 2'b00, 1'b0, 16'hA534, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("r_data_hold", 32'(bus.r_data), 32'h0000A534);
        wr0(4, 16'hCD00, 2'b10);

        // Out-of-range read clears r_data; out-of-range write touches nothing
        do_req(0, 1'b0, 13, 16'h0000, 2'b00, 1'b1, 16'h0000, 1);
        wr0(14, 16'hFFFF, 2'b11);
        for (int a = 0; a < D; a++) rd0(a);

        // Contention from pointer 0, then continuous re-requests
        do_reset();
        grant_log.delete();
        fork
            begin
                do_req(0, 1'b1, 5, 16'h00FF, 2'b11, 1'b0, 16'h0000, 1);
                do_req(0, 1'b1, 9, 16'h1111, 2'b11, 1'b0, 16'h0000, 0);
                do_req(0, 1'b1, 10, 16'h2222, 2'b11, 1'b0, 16'h0000, 0);
            end
            begin
                do_req(1, 1'b0, 5, 16'h0000, 2'b00, 1'b0, 16'h00FF, 3);
                do_req(1, 1'b0, 5, 16'h0000, 2'b00, 1'b0, 16'h00FF, 0);
                do_req(1, 1'b0, 5, 16'h0000, 2'b00, 1'b0, 16'h00FF, 0);
            end
        join
        chk("grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            chk($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));
        end

        // Reset during the ACCESS cycle of a write
        q0.push_back('{err: 1'b0, rd: 16'h0000});
        bus.wr_rd[0]      = 1'b1;
        bus.addr[0 +: AW] = AW'(7);
        bus.w_data[0 +: W] = 16'hBEEF;
        bus.wstrb[0 +: 2] = 2'b11;
        bus.valid[0]      = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.ready[0] && lat < 60);
        chk("rst_write_latency", 32'(lat), 32'd1);
        rst = 1'b1;
        bus.valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.ready), 32'd0);
        chk("err_after_rst", 32'(bus.err), 32'd0);
        rst = 1'b0;
        do_req(0, 1'b0, 7, 16'h0000, 2'b00, 1'b0, CLEAR ? 16'h0000 : 16'hBEEF, CLEAR ? D + 1 : 1);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
